axi_cfg_arbiter: RTL and testbench

AXI_CFG_ARBITER -- requirements
Module: axi_cfg_arbiter

---
 rtl/axi_cfg_pkg.sv | 6 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/axi_cfg_arbiter.sv | 126 ++++++++++++
 tb/tb_axi_cfg_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cfg_pkg.sv
// axi_cfg_pkg: shared FSM encoding and AXI response codes for the config arbiter
package axi_cfg_pkg;
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RRESP, DONE} state_e;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick over a request vector; search starts after the last enabled grant
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = $clog2(N)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] ptr;
  logic [IW-1:0] c;
  // Descending scan so the candidate closest to ptr is written last and wins
  always_comb begin
    idx = '0;
    c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      c = IW'((int'(ptr) + i) % N);
      if (req[c]) idx = c;
    end
    grant = (|req) ? N'(1) << idx : '0;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) ptr <= '0;
    else if (en && |req) ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
endmodule

// File: rtl/axi_cfg_arbiter.sv
// axi_cfg_arbiter: funnels NUM_REQ simple request ports onto one AXI4-Lite master,
// one transaction in flight, round-robin between requesters.
module axi_cfg_arbiter
  import axi_cfg_pkg::*;
#(
  parameter  int NUM_REQ        = 2,
  parameter  int AXI_ADDR_WIDTH = 32,
  parameter  int AXI_DATA_WIDTH = 32,
  localparam int IW             = $clog2(NUM_REQ),
  localparam int SW             = AXI_DATA_WIDTH / 8
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ-1:0]                req_we,
  input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*AXI_DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*SW-1:0]             req_wstrb,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                        rsp_resp,
  output logic                              busy,
  output logic [IW-1:0]                     grant_idx,
  output logic [AXI_ADDR_WIDTH-1:0]         m_axi_awaddr,
  output logic                              m_axi_awvalid,
  input  logic                              m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]         m_axi_wdata,
  output logic [SW-1:0]                     m_axi_wstrb,
  output logic                              m_axi_wvalid,
  input  logic                              m_axi_wready,
  input  logic [1:0]                        m_axi_bresp,
  input  logic                              m_axi_bvalid,
  output logic                              m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]         m_axi_araddr,
  output logic                              m_axi_arvalid,
  input  logic                              m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]         m_axi_rdata,
  input  logic [1:0]                        m_axi_rresp,
  input  logic                              m_axi_rvalid,
  output logic                              m_axi_rready
);
  state_e                    state, nxt;
  logic [NUM_REQ-1:0]        grant;
  logic [IW-1:0]             win;
  logic                      accept, aw_hs, w_hs, aw_done, w_done;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]             wstrb_q;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .req     (req_valid),
    .en      (state == IDLE),
    .grant   (grant),
    .idx     (win)
  );

  assign accept = state == IDLE && |req_valid;
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (accept) nxt = req_we[win] ? WADDR : RADDR;
      WADDR:   if ((aw_done || aw_hs) && (w_done || w_hs)) nxt = WRESP;
      WRESP:   if (m_axi_bvalid) nxt = DONE;
      RADDR:   if (m_axi_arready) nxt = RRESP;
      RRESP:   if (m_axi_rvalid) nxt = DONE;
      default: nxt = IDLE;
    endcase
  end

  // AW and W retire independently; each valid drops once its own handshake is recorded
  always_comb begin
    req_ready     = (state == IDLE) ? grant : '0;
    m_axi_awvalid = state == WADDR && !aw_done;
    m_axi_wvalid  = state == WADDR && !w_done;
    m_axi_bready  = state == WRESP;
    m_axi_arvalid = state == RADDR;
    m_axi_rready  = state == RRESP;
    m_axi_awaddr  = addr_q;
    m_axi_araddr  = addr_q;
    m_axi_wdata   = wdata_q;
    m_axi_wstrb   = wstrb_q;
    rsp_valid     = (state == DONE) ? NUM_REQ'(1) << grant_idx : '0;
    busy          = state != IDLE;
  end

  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      grant_idx <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= OKAY;
    end else begin
      if (accept) begin
        grant_idx <= win;
        addr_q    <= req_addr[win*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        wdata_q   <= req_wdata[win*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        wstrb_q   <= req_wstrb[win*SW +: SW];
        aw_done   <= 1'b0;
        w_done    <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs) w_done <= 1'b1;
      if (m_axi_bvalid && m_axi_bready) begin
        rsp_resp  <= m_axi_bresp;
        rsp_rdata <= '0;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        rsp_resp  <= m_axi_rresp;
        rsp_rdata <= m_axi_rdata;
      end
    end
endmodule

// File: tb/tb_axi_cfg_arbiter.sv
// tb_axi_cfg_arbiter: directed + random requests against a delay-configurable AXI-Lite slave,
// scoreboard fed by a round-robin/memory reference model.
module tb_axi_cfg_arbiter;
  import axi_cfg_pkg::*;
  localparam int N = 2, AW = 32, DW = 32, SW = DW / 8, IW = $clog2(N);

  logic aclk, aresetn;
  logic [N-1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0] rsp_rdata, m_axi_wdata, m_axi_rdata;
  logic [1:0] rsp_resp, m_axi_bresp, m_axi_rresp;
  logic busy;
  logic [IW-1:0] grant_idx;
  logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
  logic [SW-1:0] m_axi_wstrb;
  logic m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready, m_axi_bvalid, m_axi_bready;
  logic m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;

  axi_cfg_arbiter #(.NUM_REQ(N), .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .grant_idx(grant_idx),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_chk, n_pass;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Slave: each ready waits <dly> cycles of valid; responses come <dly> cycles after the request completes
  int aw_dly, w_dly, ar_dly, b_dly, r_dly;
  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic s_err, got_aw, got_w;
  logic [AW-1:0] s_awaddr, s_wa;
  logic [DW-1:0] s_wdata, s_wd;
  logic [SW-1:0] s_wstrb, s_ws;
  logic [DW-1:0] smem [16];

  assign m_axi_awready = m_axi_awvalid && aw_cnt >= aw_dly;
  assign m_axi_wready  = m_axi_wvalid && w_cnt >= w_dly;
  assign m_axi_arready = m_axi_arvalid && ar_cnt >= ar_dly;
  assign s_wa = got_aw ? s_awaddr : m_axi_awaddr;
  assign s_wd = got_w ? s_wdata : m_axi_wdata;
  assign s_ws = got_w ? s_wstrb : m_axi_wstrb;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; m_axi_bvalid <= 1'b0; m_axi_rvalid <= 1'b0;
      m_axi_bresp <= OKAY; m_axi_rresp <= OKAY; m_axi_rdata <= '0;
    end else begin
      aw_cnt <= (m_axi_awvalid && !m_axi_awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (m_axi_wvalid && !m_axi_wready) ? w_cnt + 1 : 0;
      ar_cnt <= (m_axi_arvalid && !m_axi_arready) ? ar_cnt + 1 : 0;
      if (m_axi_awvalid && m_axi_awready) begin got_aw <= 1'b1; s_awaddr <= m_axi_awaddr; end
      if (m_axi_wvalid && m_axi_wready) begin got_w <= 1'b1; s_wdata <= m_axi_wdata; s_wstrb <= m_axi_wstrb; end
      if (b_cnt > 0) begin b_cnt <= b_cnt - 1; if (b_cnt == 1) m_axi_bvalid <= 1'b1; end
      if (r_cnt > 0) begin r_cnt <= r_cnt - 1; if (r_cnt == 1) m_axi_rvalid <= 1'b1; end
      if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
      if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
      if ((got_aw || (m_axi_awvalid && m_axi_awready)) && (got_w || (m_axi_wvalid && m_axi_wready))) begin
        got_aw <= 1'b0; got_w <= 1'b0;
        for (int b = 0; b < SW; b++) if (!s_err && s_ws[b]) smem[s_wa[5:2]][8*b +: 8] <= s_wd[8*b +: 8];
        m_axi_bresp <= s_err ? SLVERR : OKAY;
        if (b_dly == 0) m_axi_bvalid <= 1'b1; else b_cnt <= b_dly;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        m_axi_rdata <= s_err ? '0 : smem[m_axi_araddr[5:2]];
        m_axi_rresp <= s_err ? SLVERR : OKAY;
        if (r_dly == 0) m_axi_rvalid <= 1'b1; else r_cnt <= r_dly;
      end
    end
  end

  // Reference model: round-robin winner, word memory, expected responses in issue order
  typedef struct { int idx; logic [DW-1:0] rdata; logic [1:0] resp; int hs_cyc; logic zw; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  logic [DW-1:0] ref_mem [16];
  int last, pick, wi, cyc, aw_n, w_n, b_n, ar_n, r_n, af_n;
  logic aw_pend, w_pend, ar_pend;
  logic [AW-1:0] aw_prev, ar_prev;
  logic [DW+SW-1:0] w_prev;

  function automatic int rr_pick(input logic [N-1:0] v, input int l);
    for (int k = 1; k <= N; k++) if (v[IW'((l + k) % N)]) return (l + k) % N;
    return -1;
  endfunction
  function automatic logic [N-1:0] oh(input int i);
    return (i < 0) ? '0 : N'(1) << i;
  endfunction

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 16; i++) begin smem[i] = '0; ref_mem[i] = '0; end
    forever begin
      @(negedge aclk or negedge aresetn);
      if (!aresetn) begin
        exp_q.delete();
        last = N - 1;
        aw_n = 0; w_n = 0; b_n = 0; ar_n = 0; r_n = 0;
        aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
      end else begin
        if (|req_ready) begin
          pick = rr_pick(req_valid, last);
          chk("grant", req_ready, oh(pick));
          if (pick >= 0 && req_ready == oh(pick)) begin
            last = pick;
            wi = int'(req_addr[pick*AW + 2 +: 4]);
            e.idx = pick; e.hs_cyc = cyc; e.resp = s_err ? SLVERR : OKAY;
            e.zw = (aw_dly + w_dly + ar_dly + b_dly + r_dly) == 0;
            if (req_we[pick]) begin
              e.rdata = '0;
              for (int b = 0; b < SW; b++)
                if (!s_err && req_wstrb[pick*SW + b]) ref_mem[wi][8*b +: 8] = req_wdata[pick*DW + 8*b +: 8];
            end else e.rdata = s_err ? '0 : ref_mem[wi];
            exp_q.push_back(e);
          end
        end
        if (|rsp_valid) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_valid", rsp_valid, oh(e.idx));
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            chk("grant_idx", grant_idx, e.idx);
            if (e.zw) chk("latency", cyc - e.hs_cyc, 3);
          end
        end
        if (aw_pend) chk("aw_stable", {m_axi_awvalid, m_axi_awaddr}, {1'b1, aw_prev});
        if (w_pend) chk("w_stable", {m_axi_wvalid, m_axi_wdata, m_axi_wstrb}, {1'b1, w_prev});
        if (ar_pend) chk("ar_stable", {m_axi_arvalid, m_axi_araddr}, {1'b1, ar_prev});
        if (m_axi_awvalid && m_axi_awready) begin chk("overlap_aw", {aw_n - b_n, ar_n - r_n}, 0); aw_n++; end
        if (m_axi_wvalid && m_axi_wready) begin chk("overlap_w", {w_n - b_n, ar_n - r_n}, 0); w_n++; end
        if (m_axi_arvalid && m_axi_arready) begin chk("overlap_ar", {aw_n - b_n, ar_n - r_n}, 0); ar_n++; end
        if (m_axi_bvalid && m_axi_bready) b_n++;
        if (m_axi_rvalid && m_axi_rready) r_n++;
        if (!m_axi_awvalid && m_axi_wvalid) af_n++;
        aw_pend = m_axi_awvalid && !m_axi_awready; aw_prev = m_axi_awaddr;
        w_pend = m_axi_wvalid && !m_axi_wready; w_prev = {m_axi_wdata, m_axi_wstrb};
        ar_pend = m_axi_arvalid && !m_axi_arready; ar_prev = m_axi_araddr;
      end
    end
  end

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
    req_we[i] = we; req_addr[i*AW +: AW] = a; req_wdata[i*DW +: DW] = d; req_wstrb[i*SW +: SW] = s;
  endtask

  task automatic fire(input logic [N-1:0] m);
    logic [N-1:0] hs;
    int t = 0;
    req_valid = m;
    while (req_valid != 0 && t < 200) begin
      @(negedge aclk); hs = req_valid & req_ready;
      @(posedge aclk); #1; req_valid = req_valid & ~hs; t++;
    end
    if (req_valid != 0) begin chk("req_timeout", req_valid, 0); req_valid = '0; end
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 200) begin @(posedge aclk); #1; t++; end
    if (t >= 200) chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic set_dly(input int a, input int w, input int r, input int b, input int rd);
    aw_dly = a; w_dly = w; ar_dly = r; b_dly = b; r_dly = rd;
  endtask

  task automatic chk_zero();
    chk("rst_ctrl", {req_ready, rsp_valid, busy, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                     m_axi_arvalid, m_axi_rready}, 0);
    chk("rst_rsp", {rsp_rdata, rsp_resp}, 0);
    chk("rst_addr", {m_axi_awaddr, m_axi_araddr}, 0);
    chk("rst_wdata", {m_axi_wdata, m_axi_wstrb}, 0);
    chk("rst_gidx", grant_idx, 0);
  endtask

  int aw0, w0, b0, af0, t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    s_err = 1'b0; set_dly(0, 0, 0, 0, 0);
    repeat (3) @(posedge aclk);
    #1 chk_zero();
    @(negedge aclk) aresetn = 1'b1;
    @(posedge aclk); #1;
    // zero-wait write from requester 0
    set_req(0, 1'b1, 32'h0, 32'h33445566, 4'hF);
    fire(2'b01); drain();
    chk("aw_count", aw_n, 1);
    chk("w_count", w_n, 1);
    // read it back through requester 1
    set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
    fire(2'b10); drain();
    // simultaneous requests, twice
    set_req(0, 1'b1, 32'hC, 32'hA5A5_0001, 4'hF); set_req(1, 1'b0, 32'hC, 32'h0, 4'h0);
    fire(2'b11); drain();
    set_req(0, 1'b0, 32'hC, 32'h0, 4'h0); set_req(1, 1'b1, 32'hC, 32'h1234_5678, 4'h3);
    fire(2'b11); drain();
    // AW accepted three cycles ahead of W
    set_dly(0, 3, 0, 0, 0);
    aw0 = aw_n; w0 = w_n; b0 = b_n; af0 = af_n;
    set_req(1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    fire(2'b10); drain();
    chk("split_aw", aw_n - aw0, 1);
    chk("split_w", w_n - w0, 1);
    chk("split_b", b_n - b0, 1);
    chk("aw_before_w", af_n - af0, 3);
    // slave error on a read
    set_dly(0, 0, 0, 0, 0); s_err = 1'b1;
    set_req(1, 1'b0, 32'h10, 32'h0, 4'h0);
    fire(2'b10); drain();
    chk("idle_after_err", busy, 0);
    s_err = 1'b0;
    // requester 1 raises and withdraws its request while a slow read is in flight
    set_dly(0, 0, 0, 0, 6);
    set_req(0, 1'b0, 32'h10, 32'h0, 4'h0);
    fire(2'b01);
    req_valid[1] = 1'b1;
    repeat (3) @(posedge aclk);
    #1 req_valid[1] = 1'b0;
    drain();
    chk("no_grant_dropped", grant_idx, 0);
    // reset while waiting for the write response
    set_dly(0, 0, 0, 8, 0);
    set_req(0, 1'b1, 32'h8, 32'hCAFE_F00D, 4'hF);
    fire(2'b01);
    t = 0;
    while (!m_axi_bready && t < 50) begin @(negedge aclk); t++; end
    chk("reached_wresp", m_axi_bready, 1);
    #2 aresetn = 1'b0;
    #1 chk_zero();
    repeat (3) @(posedge aclk);
    @(negedge aclk) aresetn = 1'b1;
    set_dly(0, 0, 0, 0, 0);
    repeat (12) @(posedge aclk);
    #1 chk("no_rsp_after_rst", exp_q.size(), 0);
    set_req(1, 1'b0, 32'h8, 32'h0, 4'h0);
    fire(2'b10); drain();
    // random traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 2) == 0) set_dly(0, 0, 0, 0, 0);
      else set_dly($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 2), $urandom_range(0, 2));
      s_err = $urandom_range(0, 7) == 0;
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3) * 4), $urandom,
                SW'($urandom_range(1, 15)));
      fire(N'($urandom_range(1, (1 << N) - 1)));
      drain();
    end
    s_err = 1'b0;
    chk("final_queue", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
